// File: rtl/round_sequencer.sv
// Round sequencer: steps a maze game through attract, get-ready, play,
// death animation and game-over phases. It also issues the spawn-reset
// pulse and gives an in-state frame counter for the animation index.
module round_sequencer #(
    parameter int unsigned READY_FRAMES = 120,
    parameter int unsigned DEATH_FRAMES = 90,
    parameter int unsigned OVER_FRAMES  = 180
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start_of_frame,
    input  logic       start_key,
    input  logic       lost_life,
    input  logic       is_pm_alive,
    input  logic       level_cleared,
    output logic       game_started,
    output logic       freeze,
    output logic       reset_positions,
    output logic       ready_banner,
    output logic       death_anim,
    output logic       game_over,
    output logic [7:0] frame_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READY     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_DYING     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    // Last frame_cnt value of each timed state. The exit happens on the
    // start_of_frame that arrives while the counter holds this value.
    localparam logic [7:0] READY_LAST = 8'(READY_FRAMES - 1);
    localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
    localparam logic [7:0] OVER_LAST  = 8'(OVER_FRAMES - 1);

    state_t     state_q, state_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       reset_positions_q, reset_positions_d;

    // State, frame counter and spawn pulse registers; reset forces IDLE with no pulse
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q           <= ST_IDLE;
            frame_cnt_q       <= 8'd0;
            reset_positions_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            frame_cnt_q       <= frame_cnt_d;
            reset_positions_q <= reset_positions_d;
        end
    end

    // Next-state logic: transitions, spawn-reset requests and the in-state frame counter
    always_comb begin
        state_d           = state_q;
        reset_positions_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_key) begin
                    state_d           = ST_READY;
                    reset_positions_d = 1'b1;
                end
            end
            ST_READY: begin
                if (start_of_frame && (frame_cnt_q == READY_LAST)) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // A death takes priority over a level clear in the same cycle
                if (lost_life) begin
                    state_d = ST_DYING;
                end else if (level_cleared) begin
                    state_d           = ST_READY;
                    reset_positions_d = 1'b1;
                end
            end
            ST_DYING: begin
                if (start_of_frame && (frame_cnt_q == DEATH_LAST)) begin
                    if (is_pm_alive) begin
                        state_d           = ST_READY;
                        reset_positions_d = 1'b1;
                    end else begin
                        state_d = ST_GAME_OVER;
                    end
                end
            end
            ST_GAME_OVER: begin
                // start_key is deliberately not looked at here
                if (start_of_frame && (frame_cnt_q == OVER_LAST)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Counter restarts on every transition, otherwise counts frames up to 255
        if (state_d != state_q) begin
            frame_cnt_d = 8'd0;
        end else if (start_of_frame && (frame_cnt_q != 8'hFF)) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Output decode: phase flags come from the registered state alone
    always_comb begin
        game_started = 1'b0;
        freeze       = 1'b1;
        ready_banner = 1'b0;
        death_anim   = 1'b0;
        game_over    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                game_started = 1'b0;
                freeze       = 1'b1;
            end
            ST_READY: begin
                game_started = 1'b1;
                freeze       = 1'b1;
                ready_banner = 1'b1;
            end
            ST_PLAY: begin
                game_started = 1'b1;
                freeze       = 1'b0;
            end
            ST_DYING: begin
                game_started = 1'b1;
                freeze       = 1'b1;
                death_anim   = 1'b1;
            end
            ST_GAME_OVER: begin
                // Dropping game_started lets the life manager reload lives
                game_started = 1'b0;
                freeze       = 1'b1;
                game_over    = 1'b1;
            end
            default: begin
                game_started = 1'b0;
                freeze       = 1'b1;
            end
        endcase
    end

    assign reset_positions = reset_positions_q;
    assign frame_cnt       = frame_cnt_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer. Expected output vectors are pushed to
// a queue as each stimulus step is driven and popped when the DUT output
// for that step is sampled, #1 after the rising edge.
module tb_round_sequencer;

  localparam int W = 14;  // {game_started, freeze, reset_positions, ready_banner, death_anim, game_over, frame_cnt}

  logic       clk;
  logic       resetN;
  logic       start_of_frame;
  logic       start_key;
  logic       lost_life;
  logic       is_pm_alive;
  logic       level_cleared;
  logic       game_started;
  logic       freeze;
  logic       reset_positions;
  logic       ready_banner;
  logic       death_anim;
  logic       game_over;
  logic [7:0] frame_cnt;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  round_sequencer #(
    .READY_FRAMES(120),
    .DEATH_FRAMES(90),
    .OVER_FRAMES (180)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .start_of_frame (start_of_frame),
    .start_key      (start_key),
    .lost_life      (lost_life),
    .is_pm_alive    (is_pm_alive),
    .level_cleared  (level_cleared),
    .game_started   (game_started),
    .freeze         (freeze),
    .reset_positions(reset_positions),
    .ready_banner   (ready_banner),
    .death_anim     (death_anim),
    .game_over      (game_over),
    .frame_cnt      (frame_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference output vectors per phase
  function automatic logic [W-1:0] v_idle(input logic [7:0] c);
    return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, c};
  endfunction
  function automatic logic [W-1:0] v_ready(input logic rp, input logic [7:0] c);
    return {1'b1, 1'b1, rp, 1'b1, 1'b0, 1'b0, c};
  endfunction
  function automatic logic [W-1:0] v_play(input logic rp, input logic [7:0] c);
    return {1'b1, 1'b0, rp, 1'b0, 1'b0, 1'b0, c};
  endfunction
  function automatic logic [W-1:0] v_dying(input logic [7:0] c);
    return {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, c};
  endfunction
  function automatic logic [W-1:0] v_over(input logic [7:0] c);
    return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, c};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one frame: a single-cycle start_of_frame pulse followed by a quiet cycle
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      start_of_frame = 1'b1;
      tick();
      start_of_frame = 1'b0;
      tick();
    end
  endtask

  task automatic push(input logic [W-1:0] e);
    exp_q.push_back(e);
  endtask

  // scoreboard: pop the oldest expectation and compare with the sampled outputs
  task automatic check(input string tag);
    logic [W-1:0] obs;
    logic [W-1:0] e;
    obs = {game_started, freeze, reset_positions, ready_banner, death_anim, game_over, frame_cnt};
    n_checks++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: observed %h but no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  initial begin
    resetN         = 1'b0;
    start_of_frame = 1'b0;
    start_key      = 1'b0;
    lost_life      = 1'b0;
    is_pm_alive    = 1'b1;
    level_cleared  = 1'b0;

    // reset values, with inputs active that must be ignored
    start_key = 1'b1;
    push(v_idle(8'd0));
    tick(); tick();
    check("reset_hold");
    start_key = 1'b0;
    resetN    = 1'b1;

    // start: first edge after release is usable
    start_key = 1'b1;
    push(v_ready(1'b1, 8'd0));
    tick();
    check("start_ready_pulse");
    start_key = 1'b0;
    push(v_ready(1'b0, 8'd0));
    tick();
    check("start_pulse_one_cycle");

    push(v_ready(1'b0, 8'd119));
    frames(119);
    check("ready_cnt_119");

    // lost_life outside PLAY is ignored
    lost_life = 1'b1;
    push(v_ready(1'b0, 8'd119));
    tick();
    check("ready_ignores_lost_life");
    lost_life = 1'b0;

    push(v_play(1'b0, 8'd0));
    frames(1);
    check("ready_to_play");

    push(v_play(1'b0, 8'd3));
    frames(3);
    check("play_cnt_3");
    push(v_play(1'b0, 8'd255));
    frames(260);
    check("play_cnt_saturates");

    // level clear
    level_cleared = 1'b1;
    push(v_ready(1'b1, 8'd0));
    tick();
    check("level_clear_ready");
    level_cleared = 1'b0;
    push(v_ready(1'b0, 8'd0));
    tick();
    check("level_clear_pulse_one_cycle");
    push(v_play(1'b0, 8'd0));
    frames(120);
    check("level_clear_back_to_play");

    // simultaneous lost_life and level_cleared: death wins, no spawn pulse
    is_pm_alive   = 1'b1;
    lost_life     = 1'b1;
    level_cleared = 1'b1;
    push(v_dying(8'd0));
    tick();
    check("simultaneous_dying");
    lost_life     = 1'b0;
    level_cleared = 1'b0;
    push(v_dying(8'd0));
    tick();
    check("simultaneous_no_pulse");
    push(v_dying(8'd89));
    frames(89);
    check("dying_cnt_89");

    // dying exit with a life left
    start_of_frame = 1'b1;
    push(v_ready(1'b1, 8'd0));
    tick();
    check("death_to_ready_pulse");
    start_of_frame = 1'b0;
    push(v_ready(1'b0, 8'd0));
    tick();
    check("death_ready_pulse_drop");
    push(v_play(1'b0, 8'd0));
    frames(120);
    check("death_back_to_play");

    // final death
    is_pm_alive = 1'b0;
    lost_life   = 1'b1;
    push(v_dying(8'd0));
    tick();
    check("final_death_dying");
    lost_life = 1'b0;
    push(v_over(8'd0));
    frames(90);
    check("game_over_entry");

    // start_key ignored during GAME_OVER
    start_key = 1'b1;
    push(v_over(8'd179));
    frames(179);
    check("game_over_ignores_start");

    // exit to IDLE with start_key still held: new game one cycle later
    start_of_frame = 1'b1;
    push(v_idle(8'd0));
    tick();
    check("game_over_to_idle");
    start_of_frame = 1'b0;
    push(v_ready(1'b1, 8'd0));
    tick();
    check("held_start_restarts");
    start_key   = 1'b0;
    is_pm_alive = 1'b1;

    // reset mid-DYING at frame 45
    push(v_play(1'b0, 8'd0));
    frames(120);
    check("reset_test_play");
    lost_life = 1'b1;
    tick();
    lost_life = 1'b0;
    push(v_dying(8'd45));
    frames(45);
    check("dying_cnt_45");
    #2;
    resetN = 1'b0;
    push(v_idle(8'd0));
    #1;
    check("async_reset_mid_dying");
    tick();
    resetN = 1'b1;
    push(v_idle(8'd255));
    frames(300);
    check("idle_stays_300_frames");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
